// File: rtl/pu_msp430_mailbox_pkg.sv
// pu_msp430_mailbox_pkg
// Shared constants for the CPU <-> host mailbox peripheral.
// Holds the register word offsets, the bit positions inside CTL and STAT,
// and the width of the FIFO occupancy counters.
package pu_msp430_mailbox_pkg;

  // Word offsets inside the 4-word register window
  localparam logic [1:0] REG_CTL    = 2'd0;
  localparam logic [1:0] REG_STAT   = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  // CTL bit positions
  localparam int CTL_TXIE    = 0;
  localparam int CTL_RXIE    = 1;
  localparam int CTL_TXFLUSH = 2;
  localparam int CTL_RXFLUSH = 3;

  // STAT bit positions
  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_TX_OVF    = 4;
  localparam int STAT_RX_UNF    = 5;
  localparam int STAT_TXCNT_LSB = 8;
  localparam int STAT_RXCNT_LSB = 12;

  // Occupancy counter width; covers 0..4 entries
  localparam int CNT_W = 3;

endpackage

// File: rtl/pu_msp430_mailbox_fifo.sv
// pu_msp430_mailbox_fifo
// Small synchronous 16-bit FIFO used for both mailbox directions.
// Ports:
//   mclk, puc_rst : clock and synchronous active-high reset
//   push, pop     : enqueue din / dequeue head (ignored when illegal)
//   flush         : empties the FIFO; overrides a coincident push/pop
//   din           : write data
//   dout          : head entry, 16'h0000 while empty
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module pu_msp430_mailbox_fifo
  import pu_msp430_mailbox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [15:0]      din,
  output logic [15:0]      dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, so the slot being freed is reused.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? 16'h0000 : mem[rd_ptr];

  // Storage needs no reset; the empty flag masks stale contents.
  always_ff @(posedge mclk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge mclk) begin
    if (puc_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pu_msp430_mailbox.sv
// pu_msp430_mailbox
// Peripheral-bus mailbox between the MSP430 CPU and an external host agent.
// TX FIFO: CPU writes TXDATA, host drains via tx_valid/tx_ready.
// RX FIFO: host fills via rx_valid/rx_ready, CPU reads RXDATA.
// Ports:
//   mclk, puc_rst                       : clock, synchronous active-high reset
//   per_en/per_we/per_addr/per_din      : peripheral bus request
//   per_dout                            : read data, zero when not selected
//   dbg_halt_st                         : CPU halted; RXDATA reads do not pop
//   tx_data/tx_valid/tx_ready           : host-side TX stream
//   rx_data/rx_valid/rx_ready           : host-side RX stream
//   irq                                 : registered level interrupt
module pu_msp430_mailbox
  import pu_msp430_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0190,
  parameter int          DEPTH     = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  input  logic        dbg_halt_st,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  logic             sel;
  logic             reg_rd;
  logic             reg_wr;
  logic [1:0]       reg_off;
  logic             ctl_wr_lo;
  logic             stat_wr_lo;

  logic             txie;
  logic             rxie;
  logic             tx_ovf;
  logic             rx_unf;

  logic             tx_push;
  logic             tx_pop;
  logic             tx_flush;
  logic [15:0]      tx_push_data;
  logic             tx_full;
  logic             tx_empty;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_ovf_set;

  logic             rx_push;
  logic             rx_pop;
  logic             rx_flush;
  logic             rx_rd;
  logic [15:0]      rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_unf_set;

  logic [15:0]      stat;

  assign sel     = per_en & (per_addr[13:2] == BASE_ADDR[14:3]);
  assign reg_off = per_addr[1:0];
  assign reg_rd  = sel & (per_we == 2'b00);
  assign reg_wr  = sel & (per_we != 2'b00);

  // Only the low byte of CTL/STAT holds writable bits.
  assign ctl_wr_lo  = reg_wr & (reg_off == REG_CTL)  & per_we[0];
  assign stat_wr_lo = reg_wr & (reg_off == REG_STAT) & per_we[0];

  assign tx_flush = ctl_wr_lo & per_din[CTL_TXFLUSH];
  assign rx_flush = ctl_wr_lo & per_din[CTL_RXFLUSH];

  // Byte writes to TXDATA push the word with the unwritten byte zeroed.
  assign tx_push      = reg_wr & (reg_off == REG_TXDATA);
  assign tx_push_data = {per_we[1] ? per_din[15:8] : 8'h00,
                         per_we[0] ? per_din[7:0]  : 8'h00};

  // Handshake qualifiers depend only on FIFO state, never on the host inputs.
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  // A halted CPU (debugger peeking) must not consume RX data or flag underflow.
  assign rx_rd      = reg_rd & (reg_off == REG_RXDATA) & ~dbg_halt_st;
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_unf_set = rx_rd & rx_empty;

  // A flush silently discards the coincident push, so no overflow then.
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop & ~tx_flush;

  pu_msp430_mailbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .push    (tx_push),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .din     (tx_push_data),
    .dout    (tx_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_cnt)
  );

  pu_msp430_mailbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .din     (rx_data),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_cnt)
  );

  // Sticky error flags are only set by TXDATA/RXDATA accesses, which can never
  // coincide with a STAT write, so set and clear never collide.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      txie   <= 1'b0;
      rxie   <= 1'b0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctl_wr_lo) begin
        txie <= per_din[CTL_TXIE];
        rxie <= per_din[CTL_RXIE];
      end
      if (tx_ovf_set) begin
        tx_ovf <= 1'b1;
      end else if (stat_wr_lo && per_din[STAT_TX_OVF]) begin
        tx_ovf <= 1'b0;
      end
      if (rx_unf_set) begin
        rx_unf <= 1'b1;
      end else if (stat_wr_lo && per_din[STAT_RX_UNF]) begin
        rx_unf <= 1'b0;
      end
      irq <= (txie & tx_empty) | (rxie & ~rx_empty);
    end
  end

  always_comb begin
    stat                                 = 16'h0000;
    stat[STAT_TX_FULL]                   = tx_full;
    stat[STAT_TX_EMPTY]                  = tx_empty;
    stat[STAT_RX_FULL]                   = rx_full;
    stat[STAT_RX_EMPTY]                  = rx_empty;
    stat[STAT_TX_OVF]                    = tx_ovf;
    stat[STAT_RX_UNF]                    = rx_unf;
    stat[STAT_TXCNT_LSB +: CNT_W]        = tx_cnt;
    stat[STAT_RXCNT_LSB +: CNT_W]        = rx_cnt;
  end

  // Read data is driven only during a read of this block so the bus can OR it.
  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_off)
        REG_CTL:    per_dout = {14'h0000, rxie, txie};
        REG_STAT:   per_dout = stat;
        REG_RXDATA: per_dout = rx_head;
        default:    per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_msp430_mailbox.sv
// tb_pu_msp430_mailbox
// Directed scoreboard bench for the mailbox peripheral. Stimulus pushes the
// expected read data / host-side TX words into queues; a negedge monitor pops
// and compares whenever the DUT completes a register read or a TX handshake.
module tb_pu_msp430_mailbox;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic        mclk;
  logic        puc_rst;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        dbg_halt_st;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  exp_t rd_q[$];
  exp_t tx_q[$];
  int   vectors;
  int   miscompares;

  localparam logic [15:0] A_CTL    = 16'h0190;
  localparam logic [15:0] A_STAT   = 16'h0192;
  localparam logic [15:0] A_TXDATA = 16'h0194;
  localparam logic [15:0] A_RXDATA = 16'h0196;

  pu_msp430_mailbox #(.BASE_ADDR(16'h0190), .DEPTH(4)) dut (
    .mclk        (mclk),
    .puc_rst     (puc_rst),
    .per_en      (per_en),
    .per_we      (per_we),
    .per_addr    (per_addr),
    .per_din     (per_din),
    .per_dout    (per_dout),
    .dbg_halt_st (dbg_halt_st),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Monitor: compares read data and host-side TX words against the scoreboard.
  always @(negedge mclk) begin
    exp_t e;
    if (!puc_rst) begin
      if (per_en && per_we == 2'b00) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_read: got %h, expected no read", per_dout);
        end else begin
          e = rd_q.pop_front();
          if (per_dout !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", e.tag, per_dout, e.val);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        vectors++;
        if (tx_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_tx_pop: got %h, expected no pop", tx_data);
        end else begin
          e = tx_q.pop_front();
          if (tx_data !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", e.tag, tx_data, e.val);
          end
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus cycle; called 1ns after a rising edge, returns 1ns after the next.
  task automatic applyStimulus(input logic [1:0] we, input logic [15:0] byte_addr,
                               input logic [15:0] din);
    per_en   = 1'b1;
    per_we   = we;
    per_addr = byte_addr[14:1];
    per_din  = din;
    @(posedge mclk);
    #1;
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_din  = 16'h0000;
  endtask

  task automatic cpuRead(input logic [15:0] byte_addr, input logic [15:0] expv,
                         input string tag);
    rd_q.push_back('{tag, expv});
    applyStimulus(2'b00, byte_addr, 16'h0000);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    logic [15:0] rx_vals [4];
    rx_vals[0] = 16'h1111;
    rx_vals[1] = 16'h2222;
    rx_vals[2] = 16'h3333;
    rx_vals[3] = 16'h4444;
    vectors     = 0;
    miscompares = 0;
    puc_rst     = 1'b1;
    per_en      = 1'b0;
    per_we      = 2'b00;
    per_addr    = 14'h0000;
    per_din     = 16'h0000;
    dbg_halt_st = 1'b0;
    tx_ready    = 1'b0;
    rx_data     = 16'h0000;
    rx_valid    = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    puc_rst = 1'b0;

    // Reset state
    checkOutput("reset_tx_valid", {15'h0, tx_valid}, 16'h0000);
    checkOutput("reset_rx_ready", {15'h0, rx_ready}, 16'h0001);
    checkOutput("reset_irq",      {15'h0, irq},      16'h0000);
    checkOutput("reset_tx_data",  tx_data,           16'h0000);
    cpuRead(A_STAT, 16'h000A, "reset_stat");
    cpuRead(A_CTL,  16'h0000, "reset_ctl");

    // Two words through TX
    applyStimulus(2'b11, A_TXDATA, 16'h1234);
    applyStimulus(2'b11, A_TXDATA, 16'h5678);
    cpuRead(A_STAT, 16'h0208, "stat_tx2");
    tx_q.push_back('{"tx_pop_1234", 16'h1234});
    tx_q.push_back('{"tx_pop_5678", 16'h5678});
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;
    checkOutput("tx_valid_drained", {15'h0, tx_valid}, 16'h0000);

    // Overflow: five pushes into four slots
    for (int i = 1; i <= 5; i++) applyStimulus(2'b11, A_TXDATA, 16'(i));
    cpuRead(A_STAT, 16'h0419, "stat_tx_ovf");
    applyStimulus(2'b11, A_STAT, 16'h0010);
    cpuRead(A_STAT, 16'h0409, "stat_ovf_cleared");

    // Full FIFO: CPU push and host pop in the same cycle
    tx_q.push_back('{"tx_pop_full", 16'h0001});
    tx_ready = 1'b1;
    applyStimulus(2'b11, A_TXDATA, 16'h00AA);
    tx_ready = 1'b0;
    cpuRead(A_STAT, 16'h0409, "stat_full_pushpop");

    // Flush while full with a coincident host pop
    tx_q.push_back('{"tx_pop_at_flush", 16'h0002});
    tx_ready = 1'b1;
    applyStimulus(2'b01, A_CTL, 16'h0004);
    tx_ready = 1'b0;
    cpuRead(A_STAT, 16'h000A, "stat_tx_flushed");
    checkOutput("tx_valid_flushed", {15'h0, tx_valid}, 16'h0000);

    // CTL readback and TX-empty interrupt
    applyStimulus(2'b01, A_CTL, 16'h000F);
    cpuRead(A_CTL, 16'h0003, "ctl_readback");
    checkOutput("irq_txie_empty", {15'h0, irq}, 16'h0001);
    applyStimulus(2'b01, A_CTL, 16'h0002);
    tick();
    checkOutput("irq_txie_off", {15'h0, irq}, 16'h0000);

    // Host pushes one word with RXIE set
    rx_data  = 16'hA5A5;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checkOutput("irq_latency", {15'h0, irq}, 16'h0000);
    tick();
    checkOutput("irq_rx", {15'h0, irq}, 16'h0001);
    dbg_halt_st = 1'b1;
    cpuRead(A_RXDATA, 16'hA5A5, "rx_peek_halted");
    cpuRead(A_STAT,   16'h1002, "stat_rx_not_popped");
    dbg_halt_st = 1'b0;
    cpuRead(A_RXDATA, 16'hA5A5, "rx_pop");
    tick();
    checkOutput("irq_rx_cleared", {15'h0, irq}, 16'h0000);

    // Underflow
    cpuRead(A_RXDATA, 16'h0000, "rx_empty_read");
    cpuRead(A_STAT,   16'h002A, "stat_rx_unf");
    applyStimulus(2'b01, A_STAT, 16'h0020);
    cpuRead(A_STAT,   16'h000A, "stat_unf_cleared");

    // Fill RX to the brim
    for (int i = 0; i < 4; i++) begin
      rx_data  = rx_vals[i];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    checkOutput("rx_ready_full", {15'h0, rx_ready}, 16'h0000);
    cpuRead(A_STAT, 16'h4006, "stat_rx_full");
    for (int i = 0; i < 4; i++) cpuRead(A_RXDATA, rx_vals[i], "rx_drain");
    cpuRead(A_STAT, 16'h000A, "stat_rx_drained");

    // RX flush with a coincident host push
    rx_data  = 16'h7777;
    rx_valid = 1'b1;
    applyStimulus(2'b01, A_CTL, 16'h000A);
    rx_valid = 1'b0;
    cpuRead(A_STAT, 16'h000A, "stat_rx_flush_push");
    checkOutput("rx_ready_after_flush", {15'h0, rx_ready}, 16'h0001);

    // Byte writes to TXDATA
    applyStimulus(2'b10, A_TXDATA, 16'hBEEF);
    applyStimulus(2'b01, A_TXDATA, 16'h1234);
    checkOutput("tx_data_hi_byte", tx_data, 16'hBE00);
    cpuRead(A_STAT,   16'h0208, "stat_tx_bytes");
    cpuRead(A_TXDATA, 16'h0000, "txdata_read_zero");
    tx_q.push_back('{"tx_pop_hi_byte", 16'hBE00});
    tx_q.push_back('{"tx_pop_lo_byte", 16'h0034});
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;

    // Writes to RXDATA are ignored; other addresses read zero
    applyStimulus(2'b11, A_RXDATA, 16'hFFFF);
    cpuRead(A_STAT,  16'h000A, "stat_rxdata_write_ignored");
    cpuRead(16'h0198, 16'h0000, "unselected_0198");
    cpuRead(16'h0188, 16'h0000, "unselected_0188");

    repeat (2) tick();
    vectors++;
    if (rd_q.size() != 0 || tx_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0",
               rd_q.size(), tx_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pu_msp430_mailbox.md
Name: pu_msp430_mailbox

Overview:
Peripheral-bus slave that sits directly downstream of the memory backbone's peripheral port (per_en/per_we/per_addr/per_din) and returns per_dout to it. Provides two 16-bit FIFOs between the CPU and an external host agent: TX (CPU writes, host pops via valid/ready) and RX (host pushes via valid/ready, CPU reads). Exposes control/status registers and one level interrupt.

Parameters:
BASE_ADDR, 16'h0190, byte base address; must be 8-byte aligned and below the peripheral space size.
DEPTH, 4, entries per FIFO; legal values are 2 and 4.

Ports:
mclk  in  1  main system clock
puc_rst  in  1  reset; synchronous, active-high
per_en  in  1  peripheral enable (high active)
per_we  in  2  peripheral byte write enables (high active)
per_addr  in  14  peripheral word address
per_din  in  16  peripheral write data
per_dout  out  16  read data; 16'h0000 when block not selected (OR-combined bus)
dbg_halt_st  in  1  CPU halted; RXDATA reads do not pop while high
tx_data  out  16  TX FIFO head
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  host accepts tx_data
rx_data  in  16  host data to RX FIFO
rx_valid  in  1  host offers rx_data
rx_ready  out  1  RX FIFO not full
irq  out  1  mailbox interrupt (level)

Behaviour:
- Decode: sel = per_en & (per_addr[13:2] == BASE_ADDR[14:3]); word offset = per_addr[1:0]. Read = sel & per_we==0; write = sel & per_we!=0.
- per_dout is combinational from current state in the same cycle as per_en; the backbone registers it.
- Offset 0, CTL: bit0 TXIE and bit1 RXIE are RW. Bit2 TXFLUSH and bit3 RXFLUSH are write-1 strobes and read as 0. Other bits read as 0.
- Offset 1, STAT (read-only except the sticky bits):
  - bit0 TX_FULL, bit1 TX_EMPTY, bit2 RX_FULL, bit3 RX_EMPTY.
  - bit4 TX_OVF, bit5 RX_UNF: sticky; write 1 to clear.
  - [10:8] TX count, [14:12] RX count.
- Offset 2, TXDATA: any write pushes per_din with unwritten bytes zeroed (we=01 pushes {8'h00,din[7:0]}, we=10 pushes {din[15:8],8'h00}). Reads return 0.
- Offset 3, RXDATA: a read returns the RX head and pops it when dbg_halt_st=0. A read when empty returns 0 and sets RX_UNF (only if dbg_halt_st=0). Writes are ignored.
- A CTL/STAT write applies bytes per per_we: we[0] covers bits 7:0, we[1] covers bits 15:8.
- TX push while full with no same-cycle host pop: data dropped, TX_OVF set.
- TX full with simultaneous CPU push and host pop: both take effect, count unchanged, no OVF. The same rule applies to RX.
- Host handshake: a TX pop occurs when tx_valid & tx_ready; an RX push occurs when rx_valid & rx_ready. rx_ready and tx_valid are purely state-derived, with no combinational path from tx_ready/rx_valid.
- Flush vs push/pop in the same cycle: flush wins. The FIFO becomes empty and the coincident push is discarded without setting OVF.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- irq = (TXIE & TX_EMPTY) | (RXIE & ~RX_EMPTY), registered with 1 cycle latency from the state change.
- Reset values: CTL=0, sticky flags=0, both FIFOs empty, irq=0, tx_valid=0, rx_ready=1, tx_data=0. per_dout=0 when not selected.
- Reset asserted mid-transfer: both FIFOs empty on the next edge. In-flight host handshakes in that cycle are discarded.

Decomposition:
- Package pu_msp430_mailbox_pkg holds:
  - register offset constants: CTL=0, STAT=1, TXDATA=2, RXDATA=3;
  - CTL/STAT bit-position constants;
  - the count width (3).
- One sub-module, pu_msp430_mailbox_fifo: a synchronous FIFO parameterised by DEPTH.
  - Inputs: push, pop, flush, din.
  - Outputs: dout, full, empty, count.
  - Same-cycle push+pop is supported when full.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read STAT at 16'h0192 -> 16'h000A (TX_EMPTY, RX_EMPTY); tx_valid=0, rx_ready=1, irq=0.
- CPU word-writes 16'h1234, 16'h5678 to TXDATA with tx_ready=0, then STAT -> count field 2. Raise tx_ready -> tx_data=16'h1234, then 16'h5678; tx_valid falls after the 2nd pop.
- Push 5 words with DEPTH=4 and tx_ready=0 -> STAT bit4 set, 4 entries held. Write 16'h0010 to STAT -> bit4 clears.
- Host pushes 16'hA5A5 with RXIE=1 -> irq=1 one cycle later. RXDATA read with dbg_halt_st=1 returns 16'hA5A5 and count stays 1. A read with dbg_halt_st=0 pops it; irq falls.
- Read RXDATA when empty -> per_dout=0, RX_UNF set. Byte write we=2'b10, din=16'hBEEF to TXDATA -> tx_data=16'hBE00.
- TX full plus same-cycle CPU push and host pop -> count stays 4, no OVF. TXFLUSH with a coincident push -> TX empty, no OVF. Non-selected address read -> per_dout=16'h0000.
